// File: rtl/ad_seq_pkg.sv
// ad_seq_pkg: shared types and constants for the address/data bus sequencer.
package ad_seq_pkg;

    // Default operand widths of the shared address/data mux.
    localparam int AW_DEF = 8;
    localparam int DW_DEF = 8;

    // Mux select encoding driven towards the mux_sel datapath.
    localparam logic SEL_ADDR = 1'b1;
    localparam logic SEL_DATA = 1'b0;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        DATA = 2'b10,
        DONE = 2'b11
    } seq_state_e;

endpackage : ad_seq_pkg

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester arbiter used by ad_bus_seq.
// Default build is round-robin on ties: the requester that did not win last
// time is picked. Defining AD_SEQ_FIXED_PRIO_EN switches to fixed priority,
// where requester 0 always wins a tie and last_grant_i is ignored.
module rr_arb2
    import ad_seq_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    input  logic       en_i,
    output logic       gnt_valid_o,
    output logic       gnt_id_o
);

`ifdef AD_SEQ_FIXED_PRIO_EN
    // Fixed priority keeps the port for a uniform interface but never reads it.
    logic last_grant_unused;
    assign last_grant_unused = last_grant_i;
`endif

    // Pick a winner whenever the sequencer strobes a grant.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        gnt_valid_o = en_i & (|req_i);
        gnt_id_o    = 1'b0;
        unique case (req_i)
            2'b01:   gnt_id_o = 1'b0;
            2'b10:   gnt_id_o = 1'b1;
`ifdef AD_SEQ_FIXED_PRIO_EN
            2'b11:   gnt_id_o = 1'b0;
`else
            2'b11:   gnt_id_o = ~last_grant_i;
`endif
            default: gnt_id_o = 1'b0;
        endcase
    end

endmodule : rr_arb2

// File: rtl/ad_bus_seq.sv
// ad_bus_seq: sequencer and two-way arbiter in front of the shared 8-bit
// address/data mux. Grants one write request, latches its operands, then
// drives an address phase (ALE) and a DATA_CYCLES-long data phase (write
// strobe), and finally pulses the winner's ack. All outputs are registered.
// Optional macro AD_SEQ_FIXED_PRIO_EN (inside rr_arb2) selects fixed priority
// instead of round-robin on ties.
module ad_bus_seq
    import ad_seq_pkg::*;
#(
    parameter int DW          = DW_DEF,
    parameter int AW          = AW_DEF,
    parameter int DATA_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] data0,
    output logic          ack0,
    input  logic          req1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] data1,
    output logic          ack1,
    output logic [AW-1:0] mux_addr,
    output logic [DW-1:0] mux_data,
    output logic          mux_sel,
    output logic          ale,
    output logic          wr_stb,
    output logic          busy,
    output logic          grant_id
);

    // A zero-length data phase has no meaning on the bus.
    if (DATA_CYCLES < 1) begin : g_bad_data_cycles
        $error("ad_bus_seq: DATA_CYCLES must be >= 1");
    end

    localparam int CW = $clog2(DATA_CYCLES + 1);

    seq_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic          last_grant_q;
    logic [AW-1:0] mux_addr_q;
    logic [DW-1:0] mux_data_q;
    logic          mux_sel_q;
    logic          ale_q;
    logic          wr_stb_q;
    logic          ack0_q;
    logic          ack1_q;
    logic          busy_q;
    logic          grant_id_q;

    logic          gnt_valid;
    logic          gnt_id;
    logic [AW-1:0] win_addr_d;
    logic [DW-1:0] win_data_d;

    // Requests are only considered while the sequencer is idle.
    rr_arb2 u_arb (
        .req_i        ({req1, req0}),
        .last_grant_i (last_grant_q),
        .en_i         (state_q == IDLE),
        .gnt_valid_o  (gnt_valid),
        .gnt_id_o     (gnt_id)
    );

    // Operands of the requester currently winning arbitration.
    always_comb begin
        win_addr_d = gnt_id ? addr1 : addr0;
        win_data_d = gnt_id ? data1 : data0;
    end

    // Sequencer FSM; every bus-facing output is produced as a register here.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            mux_addr_q   <= '0;
            mux_data_q   <= '0;
            mux_sel_q    <= SEL_DATA;
            ale_q        <= 1'b0;
            wr_stb_q     <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            busy_q       <= 1'b0;
            grant_id_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (gnt_valid) begin
                        mux_addr_q   <= win_addr_d;
                        mux_data_q   <= win_data_d;
                        grant_id_q   <= gnt_id;
                        last_grant_q <= gnt_id;
                        mux_sel_q    <= SEL_ADDR;
                        ale_q        <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= ADDR;
                    end
                end
                ADDR: begin
                    mux_sel_q <= SEL_DATA;
                    ale_q     <= 1'b0;
                    wr_stb_q  <= 1'b1;
                    cnt_q     <= CW'(DATA_CYCLES - 1);
                    state_q   <= DATA;
                end
                DATA: begin
                    if (cnt_q == '0) begin
                        wr_stb_q <= 1'b0;
                        ack0_q   <= ~grant_id_q;
                        ack1_q   <= grant_id_q;
                        state_q  <= DONE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                DONE: begin
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mux_addr = mux_addr_q;
    assign mux_data = mux_data_q;
    assign mux_sel  = mux_sel_q;
    assign ale      = ale_q;
    assign wr_stb   = wr_stb_q;
    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign busy     = busy_q;
    assign grant_id = grant_id_q;

endmodule : ad_bus_seq

// File: tb/tb_ad_bus_seq.sv
// tb_ad_bus_seq: directed bench for ad_bus_seq. Two instances share the same
// stimulus, one with DATA_CYCLES=2 and one with DATA_CYCLES=1. A phase-based
// transaction model predicts every output of both on every cycle; directed
// literal expectations pin the scenarios of interest.
module tb_ad_bus_seq;

    localparam int DC0 = 2;
    localparam int DC1 = 1;
`ifdef AD_SEQ_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1;
    logic [7:0] addr0, data0, addr1, data1;

    logic [7:0] m0_mux_addr, m0_mux_data, m1_mux_addr, m1_mux_data;
    logic       m0_ack0, m0_ack1, m0_mux_sel, m0_ale, m0_wr_stb, m0_busy, m0_grant_id;
    logic       m1_ack0, m1_ack1, m1_mux_sel, m1_ale, m1_wr_stb, m1_busy, m1_grant_id;

    int n_checks = 0;
    int n_err    = 0;
    int cyc_cnt  = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    ad_bus_seq #(.DW(8), .AW(8), .DATA_CYCLES(DC0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .data0(data0), .ack0(m0_ack0),
        .req1(req1), .addr1(addr1), .data1(data1), .ack1(m0_ack1),
        .mux_addr(m0_mux_addr), .mux_data(m0_mux_data), .mux_sel(m0_mux_sel),
        .ale(m0_ale), .wr_stb(m0_wr_stb), .busy(m0_busy), .grant_id(m0_grant_id)
    );

    ad_bus_seq #(.DW(8), .AW(8), .DATA_CYCLES(DC1)) u_dut1 (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .data0(data0), .ack0(m1_ack0),
        .req1(req1), .addr1(addr1), .data1(data1), .ack1(m1_ack1),
        .mux_addr(m1_mux_addr), .mux_data(m1_mux_data), .mux_sel(m1_mux_sel),
        .ale(m1_ale), .wr_stb(m1_wr_stb), .busy(m1_busy), .grant_id(m1_grant_id)
    );

    // Observed output bundle: {mux_addr, mux_data, mux_sel, ale, wr_stb, ack0, ack1, busy, grant_id}
    logic [22:0] obs0, obs1;
    assign obs0 = {m0_mux_addr, m0_mux_data, m0_mux_sel, m0_ale, m0_wr_stb, m0_ack0, m0_ack1, m0_busy, m0_grant_id};
    assign obs1 = {m1_mux_addr, m1_mux_data, m1_mux_sel, m1_ale, m1_wr_stb, m1_ack0, m1_ack1, m1_busy, m1_grant_id};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction model: phase counts cycles since grant (0 = idle),
    // 1 = address phase, 2..dc+1 = data phase, dc+2 = completion.
    int         m_phase [2] = '{0, 0};
    int         m_dc    [2] = '{DC0, DC1};
    logic [7:0] m_addr  [2] = '{8'h00, 8'h00};
    logic [7:0] m_data  [2] = '{8'h00, 8'h00};
    logic       m_gid   [2] = '{1'b0, 1'b0};
    logic       m_last  [2] = '{1'b1, 1'b1};

    always @(posedge clk) begin
        cyc_cnt++;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_phase[k] = 0;
                m_addr[k]  = 8'h00;
                m_data[k]  = 8'h00;
                m_gid[k]   = 1'b0;
                m_last[k]  = 1'b1;
            end else if (m_phase[k] == 0) begin
                if (req0 || req1) begin
                    logic win;
                    if (req0 && req1) win = FIXED ? 1'b0 : !m_last[k];
                    else              win = req1;
                    m_last[k]  = win;
                    m_gid[k]   = win;
                    m_addr[k]  = win ? addr1 : addr0;
                    m_data[k]  = win ? data1 : data0;
                    m_phase[k] = 1;
                end
            end else if (m_phase[k] == m_dc[k] + 2) begin
                m_phase[k] = 0;
            end else begin
                m_phase[k] = m_phase[k] + 1;
            end
        end
    end

    function automatic logic [22:0] exp_vec(input int k);
        int   p;
        logic sel, wr, ack;
        p   = m_phase[k];
        sel = (p == 1);
        wr  = (p >= 2) && (p <= m_dc[k] + 1);
        ack = (p == m_dc[k] + 2);
        return {m_addr[k], m_data[k], sel, sel, wr, ack && !m_gid[k], ack && m_gid[k], p != 0, m_gid[k]};
    endfunction

    // Compare both instances against the model on every cycle after reset.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_dc2", obs0, exp_vec(0));
            check("model_dc1", obs1, exp_vec(1));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req0 = 1'b0;
        req1 = 1'b0;
        rst  = 1'b1;
        step();
        step();
        rst  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    logic [7:0] gq[$];
    logic [7:0] aq[$];
    int         tq[$];

    initial begin
        int acks0, acks1;
        bit drop0, drop1;

        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        addr0 = 8'h00; data0 = 8'h00; addr1 = 8'h00; data1 = 8'h00;
        step();
        cmp_en = 1'b1;
        step();
        @(negedge clk);
        check("reset_state_dc2", obs0, 32'h0);
        check("reset_state_dc1", obs1, 32'h0);
        step();
        rst = 1'b0;

        // 1: single write from requester 0
        addr0 = 8'h50; data0 = 8'h90; req0 = 1'b1;
        step();
        req0 = 1'b0;
        @(negedge clk);
        check("t1_addr_phase", {m0_mux_sel, m0_ale, m0_mux_addr}, {1'b1, 1'b1, 8'h50});
        step(); @(negedge clk);
        check("t1_data_cycle1", {m0_mux_sel, m0_wr_stb, m0_mux_data}, {1'b0, 1'b1, 8'h90});
        step(); @(negedge clk);
        check("t1_data_cycle2", {m0_mux_sel, m0_wr_stb, m0_mux_data}, {1'b0, 1'b1, 8'h90});
        step(); @(negedge clk);
        check("t1_ack0", {m0_ack0, m0_ack1, m0_wr_stb}, {1'b1, 1'b0, 1'b0});
        step(); @(negedge clk);
        check("t1_idle", {m0_busy, m0_ack0}, {1'b0, 1'b0});
        idle(3);

        // 2: simultaneous requests, each held until acked
        do_reset();
        addr0 = 8'haa; data0 = 8'hf4; addr1 = 8'h5c; data1 = 8'hb3;
        req0 = 1'b1; req1 = 1'b1;
        acks0 = 0; acks1 = 0; drop0 = 1'b0; drop1 = 1'b0;
        gq.delete(); aq.delete();
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (m0_ack0) begin acks0++; drop0 = 1'b1; end
            if (m0_ack1) begin acks1++; drop1 = 1'b1; end
            if (m0_ale) begin gq.push_back({7'd0, m0_grant_id}); aq.push_back(m0_mux_addr); end
            step();
            if (drop0) req0 = 1'b0;
            if (drop1) req1 = 1'b0;
        end
        check("t2_ack0_count", acks0, 1);
        check("t2_ack1_count", acks1, 1);
        check("t2_grants", gq.size(), 2);
        if (gq.size() == 2) begin
            check("t2_first_gid", gq[0], 8'd0);
            check("t2_second_gid", gq[1], 8'd1);
            check("t2_second_addr", aq[1], 8'h5c);
        end
        idle(4);

        // 3: both requests held continuously for four transactions
        do_reset();
        addr0 = 8'h01; data0 = 8'h02; addr1 = 8'h03; data1 = 8'h04;
        req0 = 1'b1; req1 = 1'b1;
        gq.delete();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (m0_ale && gq.size() < 4) gq.push_back({7'd0, m0_grant_id});
            step();
            if (gq.size() == 4) begin req0 = 1'b0; req1 = 1'b0; end
        end
        check("t3_grants", gq.size(), 4);
        if (gq.size() == 4) begin
            for (int i = 0; i < 4; i++)
                check($sformatf("t3_gid%0d", i), gq[i], FIXED ? 8'd0 : 8'(i % 2));
        end
        idle(8);

        // 4: operand changes and dropped request during the transaction are ignored
        addr1 = 8'h2e; data1 = 8'h5a; req1 = 1'b1;
        step();
        @(negedge clk);
        check("t4_grant", {m0_ale, m0_grant_id, m0_mux_addr}, {1'b1, 1'b1, 8'h2e});
        step();
        addr1 = 8'h6b; data1 = 8'h1c; req1 = 1'b0;
        @(negedge clk);
        check("t4_hold_a", {m0_mux_addr, m0_mux_data}, {8'h2e, 8'h5a});
        step(); @(negedge clk);
        check("t4_hold_b", {m0_mux_addr, m0_mux_data}, {8'h2e, 8'h5a});
        step(); @(negedge clk);
        check("t4_ack1", {m0_ack0, m0_ack1}, {1'b0, 1'b1});
        idle(4);

        // 5: reset during the first data cycle, then a tie
        addr0 = 8'h11; data0 = 8'h22; req0 = 1'b1;
        step();
        req0 = 1'b0;
        step();
        rst = 1'b1;
        step();
        @(negedge clk);
        check("t5_reset_outputs", obs0, 32'h0);
        rst = 1'b0;
        addr0 = 8'h33; data0 = 8'h44; addr1 = 8'h77; data1 = 8'h88;
        req0 = 1'b1; req1 = 1'b1;
        step();
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        check("t5_tie_after_reset", {m0_ale, m0_grant_id, m0_mux_addr, m0_ack0}, {1'b1, 1'b0, 8'h33, 1'b0});
        idle(8);

        // 6: DATA_CYCLES=1 instance with req0 held gives a 4-cycle period
        addr0 = 8'hc3; data0 = 8'h3c; req0 = 1'b1;
        tq.delete();
        for (int i = 0; i < 30 && tq.size() < 3; i++) begin
            @(negedge clk);
            if (m1_ale) tq.push_back(cyc_cnt);
            step();
        end
        req0 = 1'b0;
        check("t6_transactions", tq.size(), 3);
        if (tq.size() == 3) begin
            check("t6_period_a", tq[1] - tq[0], 4);
            check("t6_period_b", tq[2] - tq[1], 4);
        end
        idle(10);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_ad_bus_seq
